// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Round-robin arbiter sharing one single-port activation/weight RAM between
//   N_REQ requesters (DMA loader, PE array, softmax unit, ...). One access is
//   granted per cycle. The granted requester drives the RAM port. Read data is
//   registered and returned with a one-hot per-requester valid one cycle after
//   the grant.
//
//   Optional feature macro: RAM_ARB_LOCK_EN
//     defined   : burst lock. A requester granted with i_lock set keeps the
//                 RAM for as long as it holds i_req and i_lock.
//     undefined : i_lock is ignored and arbitration is pure round-robin.
//
// Ports
//   i_clk       clock, all logic on posedge
//   i_rst_n     asynchronous active-low reset
//   i_req       access request, one bit per requester
//   i_we        1 = write, 0 = read, per requester
//   i_addr      packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   i_wdata     packed write data, requester k at [k*WIDTH +: WIDTH]
//   i_lock      burst lock request, per requester
//   o_gnt       one-hot grant for this cycle (combinational)
//   o_rvalid    one-hot read-data-valid pulse, one cycle after a read grant
//   o_rdata     registered read data, held until the next read
//   o_ram_we    RAM write enable
//   o_ram_addr  RAM address
//   o_ram_data  RAM write data
//   i_ram_data  RAM read data (combinational read)
// ---------------------------------------------------------------------------
module ram_arbiter #(
   parameter int N_REQ  = 4,
   parameter int WIDTH  = 264,
   parameter int ADDR_W = 10
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [N_REQ-1:0]          i_req,
   input  logic [N_REQ-1:0]          i_we,
   input  logic [N_REQ*ADDR_W-1:0]   i_addr,
   input  logic [N_REQ*WIDTH-1:0]    i_wdata,
   input  logic [N_REQ-1:0]          i_lock,
   output logic [N_REQ-1:0]          o_gnt,
   output logic [N_REQ-1:0]          o_rvalid,
   output logic [WIDTH-1:0]          o_rdata,
   output logic                      o_ram_we,
   output logic [ADDR_W-1:0]         o_ram_addr,
   output logic [WIDTH-1:0]          o_ram_data,
   input  logic [WIDTH-1:0]          i_ram_data
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  rr_ptr_r;
   logic [N_REQ-1:0]  rvalid_r;
   logic [WIDTH-1:0]  rdata_r;

   logic [N_REQ-1:0]  gnt_s;
   logic [PTR_W-1:0]  gidx_s;
   logic              any_gnt_s;
   logic [PTR_W-1:0]  base_s;
   logic              hold_s;
   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_addr_s;
   logic [WIDTH-1:0]  ram_data_s;

`ifdef RAM_ARB_LOCK_EN
   logic              lock_vld_r;
   logic [PTR_W-1:0]  lock_own_r;
`else
   logic              unused_lock_s;
   assign unused_lock_s = ^i_lock;
`endif

   // Modulo-N_REQ increment of a requester index.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(N_REQ - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   // Scan start and lock hold: after a lock release the scan restarts just
   // past the former owner, so the owner cannot immediately win again.
   always_comb begin
`ifdef RAM_ARB_LOCK_EN
      hold_s = lock_vld_r & i_req[lock_own_r] & i_lock[lock_own_r];
      base_s = lock_vld_r ? ptr_inc(lock_own_r) : rr_ptr_r;
`else
      hold_s = 1'b0;
      base_s = rr_ptr_r;
`endif
   end

   // Grant selection: first requester at or after base_s (with wrap), or the
   // lock owner while it holds its lock. Gated by reset so nothing reaches
   // the RAM while i_rst_n is low.
   always_comb begin
      logic [PTR_W:0]   sum_v;
      logic [PTR_W-1:0] idx_v;
      logic             sel_v;
      gnt_s     = '0;
      gidx_s    = '0;
      any_gnt_s = 1'b0;
      sum_v     = '0;
      idx_v     = '0;
      sel_v     = 1'b0;
`ifdef RAM_ARB_LOCK_EN
      if (hold_s) begin
         gnt_s[lock_own_r] = 1'b1;
         gidx_s            = lock_own_r;
         any_gnt_s         = 1'b1;
      end else begin
`else
      begin
`endif
         for (int i = 0; i < N_REQ; i++) begin
            sum_v = {1'b0, base_s} + (PTR_W+1)'(i);
            sum_v = (sum_v >= (PTR_W+1)'(N_REQ)) ? sum_v - (PTR_W+1)'(N_REQ) : sum_v;
            idx_v = sum_v[PTR_W-1:0];
            sel_v = ~any_gnt_s & i_req[idx_v];
            gnt_s[idx_v] = sel_v;
            gidx_s       = sel_v ? idx_v : gidx_s;
            any_gnt_s    = any_gnt_s | sel_v;
         end
      end
      gnt_s     = gnt_s & {N_REQ{i_rst_n}};
      any_gnt_s = any_gnt_s & i_rst_n;
   end

   // RAM port mux: OR of grant-masked requester fields (grant is one-hot).
   always_comb begin
      ram_we_s   = 1'b0;
      ram_addr_s = '0;
      ram_data_s = '0;
      for (int k = 0; k < N_REQ; k++) begin
         ram_we_s   = ram_we_s   | (i_we[k] & gnt_s[k]);
         ram_addr_s = ram_addr_s | (i_addr[k*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[k]}});
         ram_data_s = ram_data_s | (i_wdata[k*WIDTH +: WIDTH] & {WIDTH{gnt_s[k]}});
      end
   end

   // Read return, round-robin pointer and lock ownership.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_r <= '0;
         rvalid_r <= '0;
         rdata_r  <= '0;
`ifdef RAM_ARB_LOCK_EN
         lock_vld_r <= 1'b0;
         lock_own_r <= '0;
`endif
      end else begin
         if (any_gnt_s && !ram_we_s) begin
            rvalid_r <= gnt_s;
            rdata_r  <= i_ram_data;
         end else begin
            rvalid_r <= '0;
         end
`ifdef RAM_ARB_LOCK_EN
         if (any_gnt_s) begin
            if (i_lock[gidx_s]) begin
               // Pointer is frozen while a lock is held.
               lock_vld_r <= 1'b1;
               lock_own_r <= gidx_s;
            end else begin
               lock_vld_r <= 1'b0;
               rr_ptr_r   <= ptr_inc(gidx_s);
            end
         end else if (lock_vld_r) begin
            lock_vld_r <= 1'b0;
            rr_ptr_r   <= ptr_inc(lock_own_r);
         end
`else
         if (any_gnt_s) begin
            rr_ptr_r <= ptr_inc(gidx_s);
         end
`endif
      end
   end

   assign o_gnt      = gnt_s;
   assign o_rvalid   = rvalid_r;
   assign o_rdata    = rdata_r;
   assign o_ram_we   = ram_we_s;
   assign o_ram_addr = ram_addr_s;
   assign o_ram_data = ram_data_s;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

   localparam int N  = 4;
   localparam int W  = 264;
   localparam int AW = 4;
`ifdef RAM_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic            i_clk = 1'b0;
   logic            i_rst_n = 1'b0;
   logic [N-1:0]    i_req = '0, i_we = '0, i_lock = '0;
   logic [N*AW-1:0] i_addr = '0;
   logic [N*W-1:0]  i_wdata = '0;
   logic [N-1:0]    o_gnt, o_rvalid;
   logic [W-1:0]    o_rdata, o_ram_data, i_ram_data;
   logic            o_ram_we;
   logic [AW-1:0]   o_ram_addr;

   ram_arbiter #(.N_REQ(N), .WIDTH(W), .ADDR_W(AW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_lock(i_lock), .o_gnt(o_gnt),
      .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_ram_we(o_ram_we),
      .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data), .i_ram_data(i_ram_data)
   );

   always #5 i_clk = ~i_clk;

   // Single-port RAM with combinational read, driven by the arbiter.
   logic [W-1:0] ram [0:(1<<AW)-1];
   initial for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
   always @(posedge i_clk) if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
   assign i_ram_data = ram[o_ram_addr];

   // Stimulus state
   logic [N-1:0] t_req = '0, t_we = '0, t_lock = '0;
   logic [AW-1:0] t_addr [N];
   logic [W-1:0]  t_wdata [N];
   logic [N-1:0]  pend = '0;

   // Reference model
   logic [W-1:0] m_mem [0:(1<<AW)-1];
   int           m_ptr = 0;
   int           m_owner = -1;
   int           m_last_g = -1;
   logic [N-1:0] exp_rvalid = '0;
   logic [W-1:0] exp_rdata = '0;
   logic [N-1:0] obs_gnt;
   logic [N-1:0] hist [8];

   int n_assert = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w = '0;
      for (int i = 0; i < 9; i++) w = (w << 32) | W'($urandom());
      return w;
   endfunction

   // Who should win this cycle, from the arbitration rules.
   function automatic int model_grant();
      int base;
      if (LOCK && m_owner >= 0 && t_req[m_owner] && t_lock[m_owner]) return m_owner;
      base = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
      for (int i = 0; i < N; i++)
         if (t_req[(base + i) % N]) return (base + i) % N;
      return -1;
   endfunction

   task automatic drive();
      i_req = t_req; i_we = t_we; i_lock = t_lock;
      for (int k = 0; k < N; k++) begin
         i_addr[k*AW +: AW] = t_addr[k];
         i_wdata[k*W +: W]  = t_wdata[k];
      end
   endtask

   task automatic clear_req();
      t_req = '0; t_we = '0; t_lock = '0;
      for (int k = 0; k < N; k++) begin t_addr[k] = '0; t_wdata[k] = '0; end
   endtask

   task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic lk);
      t_req[k] = 1'b1; t_we[k] = we; t_addr[k] = a; t_wdata[k] = d; t_lock[k] = lk;
   endtask

   task automatic model_reset();
      m_ptr = 0; m_owner = -1; exp_rvalid = '0; exp_rdata = '0;
   endtask

   // One clock cycle, entered and left at a negedge.
   task automatic step();
      int g;
      logic [N-1:0] exp_g;
      chk("rvalid", W'(o_rvalid), W'(exp_rvalid));
      chk("rdata", o_rdata, exp_rdata);
      drive();
      #1;
      g = model_grant();
      exp_g = (g >= 0) ? (N'(1) << g) : '0;
      chk("gnt", W'(o_gnt), W'(exp_g));
      chk("ram_we", W'(o_ram_we), W'((g >= 0) ? t_we[g] : 1'b0));
      chk("ram_addr", W'(o_ram_addr), W'((g >= 0) ? t_addr[g] : '0));
      if (g >= 0 && t_we[g]) chk("ram_data", o_ram_data, t_wdata[g]);
      obs_gnt = o_gnt;
      m_last_g = g;
      @(posedge i_clk);
      if (g >= 0) begin
         if (t_we[g]) begin
            m_mem[t_addr[g]] = t_wdata[g];
            exp_rvalid = '0;
         end else begin
            exp_rvalid = N'(1) << g;
            exp_rdata  = m_mem[t_addr[g]];
         end
         if (LOCK && t_lock[g]) m_owner = g;
         else begin m_owner = -1; m_ptr = (g + 1) % N; end
      end else begin
         exp_rvalid = '0;
         if (m_owner >= 0) begin m_ptr = (m_owner + 1) % N; m_owner = -1; end
      end
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   initial begin
      logic [W-1:0] d4;
      for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
      clear_req();
      drive();
      @(negedge i_clk);
      do_reset();

      // 1. Reset then idle
      chk("reset_rvalid", W'(o_rvalid), W'(4'b0000));
      chk("reset_rdata", o_rdata, '0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_gnt", W'(obs_gnt), W'(4'b0000));
      end

      // 2. Req0 writes 0x1A5 to addr 7, then reads it back
      clear_req(); set_req(0, 1'b1, 4'd7, W'(12'h1A5), 1'b0);
      step();
      chk("t2_wr_gnt", W'(obs_gnt), W'(4'b0001));
      clear_req(); set_req(0, 1'b0, 4'd7, '0, 1'b0);
      step();
      chk("t2_rd_gnt", W'(obs_gnt), W'(4'b0001));
      chk("t2_rvalid", W'(o_rvalid), W'(4'b0001));
      chk("t2_rdata", o_rdata, W'(12'h1A5));
      clear_req(); step();

      // 3. All four read continuously from rr_ptr=0
      do_reset();
      clear_req();
      for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step();
         hist[i] = obs_gnt;
         chk("t3_rvalid_follows", W'(o_rvalid), W'(4'b0001 << (i % 4)));
      end
      chk("t3_g0", W'(hist[0]), W'(4'b0001));
      chk("t3_g1", W'(hist[1]), W'(4'b0010));
      chk("t3_g2", W'(hist[2]), W'(4'b0100));
      chk("t3_g3", W'(hist[3]), W'(4'b1000));
      chk("t3_g4", W'(hist[4]), W'(4'b0001));

      // 4. Req1 writes addr 3 while req2 reads addr 3
      d4 = rand_word();
      clear_req();
      set_req(1, 1'b1, 4'd3, d4, 1'b0);
      set_req(2, 1'b0, 4'd3, '0, 1'b0);
      step();
      chk("t4_first", W'(obs_gnt), W'(4'b0010));
      t_req[1] = 1'b0;
      step();
      chk("t4_second", W'(obs_gnt), W'(4'b0100));
      chk("t4_rvalid", W'(o_rvalid), W'(4'b0100));
      chk("t4_rdata", o_rdata, d4);

      // 5. Lock: move pointer to 2, then req2 locks while req0/req3 request
      clear_req(); set_req(1, 1'b0, 4'd1, '0, 1'b0);
      step();
      clear_req();
      set_req(0, 1'b0, 4'd0, '0, 1'b0);
      set_req(2, 1'b0, 4'd2, '0, 1'b1);
      set_req(3, 1'b0, 4'd3, '0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         if (i == 5) begin t_req[2] = 1'b0; t_lock[2] = 1'b0; end
         if (i == 6) t_req[3] = 1'b0;
         step();
         hist[i] = obs_gnt;
      end
      if (LOCK) begin
         for (int i = 0; i < 5; i++) chk("t5_lock_hold", W'(hist[i]), W'(4'b0100));
         chk("t5_after_owner", W'(hist[5]), W'(4'b1000));
         chk("t5_then_req0", W'(hist[6]), W'(4'b0001));
      end else begin
         chk("t5_rot0", W'(hist[0]), W'(4'b0100));
         chk("t5_rot1", W'(hist[1]), W'(4'b1000));
         chk("t5_rot2", W'(hist[2]), W'(4'b0001));
      end
      clear_req(); step();

      // Randomized traffic honouring the hold-until-grant handshake
      pend = '0;
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 2) == 0) begin
               pend[k]     = 1'b1;
               t_we[k]     = 1'($urandom());
               t_addr[k]   = AW'($urandom_range(0, 11));
               t_wdata[k]  = rand_word();
            end
            t_req[k]  = pend[k];
            t_lock[k] = pend[k] & ($urandom_range(0, 3) == 0);
         end
         step();
         if (m_last_g >= 0) pend[m_last_g] = 1'b0;
      end
      clear_req(); step();

      // 6. Reset pulsed the cycle after a read grant
      clear_req(); set_req(1, 1'b0, 4'd5, '0, 1'b0);
      step();
      clear_req();
      for (int k = 0; k < N; k++) set_req(k, 1'b1, 4'd13, rand_word(), 1'b0);
      drive();
      i_rst_n = 1'b0;
      #1;
      chk("t6_rvalid_dropped", W'(o_rvalid), W'(4'b0000));
      chk("t6_gnt_in_reset", W'(o_gnt), W'(4'b0000));
      chk("t6_we_in_reset", W'(o_ram_we), W'(1'b0));
      @(posedge i_clk);
      @(negedge i_clk);
      chk("t6_rvalid_held", W'(o_rvalid), W'(4'b0000));
      model_reset();
      i_rst_n = 1'b1;
      clear_req();
      for (int k = 0; k < N; k++) set_req(k, 1'b0, 4'd13, '0, 1'b0);
      step();
      chk("t6_first_gnt", W'(obs_gnt), W'(4'b0001));
      chk("t6_rvalid", W'(o_rvalid), W'(4'b0001));
      chk("t6_ram_zero", o_rdata, '0);
      clear_req(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
